// File: rtl/sel_pkg.sv
// Shared types for the round-robin select scheduler and the 4:1 mux stage it feeds.
package sel_pkg;

    localparam int NUM_SRC = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        IDLE,
        GRANT
    } sched_state_t;

    function automatic logic [NUM_SRC-1:0] sel_onehot(input sel_t s);
        sel_onehot    = '0;
        sel_onehot[s] = 1'b1;
    endfunction

endpackage

// File: rtl/sel_round_robin_if.sv
// Request/accept handshake and registered select outputs between sources, scheduler and mux.
interface sel_round_robin_if;
    import sel_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic               accept;
    sel_t               sel;
    logic [NUM_SRC-1:0] grant;
    logic               grant_valid;

    modport master (
        input  req,
        input  accept,
        output sel,
        output grant,
        output grant_valid
    );

    modport slave (
        output req,
        output accept,
        input  sel,
        input  grant,
        input  grant_valid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester after last, with last itself searched at the end.
module rr_pick
    import sel_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  sel_t               last_i,
    output sel_t               pick_o,
    output logic               any_o
);

    always_comb begin
        pick_o = last_i;
        any_o  = |req_i;
        case (last_i)
            2'd0: begin
                if      (req_i[1]) pick_o = 2'd1;
                else if (req_i[2]) pick_o = 2'd2;
                else if (req_i[3]) pick_o = 2'd3;
                else               pick_o = 2'd0;
            end
            2'd1: begin
                if      (req_i[2]) pick_o = 2'd2;
                else if (req_i[3]) pick_o = 2'd3;
                else if (req_i[0]) pick_o = 2'd0;
                else               pick_o = 2'd1;
            end
            2'd2: begin
                if      (req_i[3]) pick_o = 2'd3;
                else if (req_i[0]) pick_o = 2'd0;
                else if (req_i[1]) pick_o = 2'd1;
                else               pick_o = 2'd2;
            end
            2'd3: begin
                if      (req_i[0]) pick_o = 2'd0;
                else if (req_i[1]) pick_o = 2'd1;
                else if (req_i[2]) pick_o = 2'd2;
                else               pick_o = 2'd3;
            end
            default: pick_o = 2'd0;
        endcase
    end

endmodule

// File: rtl/sel_round_robin.sv
// Registered round-robin scheduler driving the 2-bit select of the downstream 4:1 mux,
// holding each grant for at most HOLD_MAX accepted beats.
module sel_round_robin
    import sel_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    sel_round_robin_if.master  bus
);

    localparam int                CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    sched_state_t       state_q, state_d;
    sel_t               sel_q, sel_d;
    sel_t               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;

    sel_t               pick_last;
    sel_t               pick;
    logic               any_req;
    logic               release_grant;

    // On a release the search must start after the holder being released, not the stale last.
    assign pick_last = (state_q == GRANT) ? sel_q : last_q;

    rr_pick u_pick (
        .req_i  (bus.req),
        .last_i (pick_last),
        .pick_o (pick),
        .any_o  (any_req)
    );

    assign release_grant = (bus.accept && (cnt_q == CNT_LAST)) || !bus.req[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (any_req) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    grant_d = sel_onehot(pick);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (any_req) begin
                        sel_d   = pick;
                        grant_d = sel_onehot(pick);
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (bus.accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            cnt_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_sel_round_robin.sv
// Scoreboard bench for sel_round_robin: directed vectors push expected outputs, a monitor pops and compares.
module tb_sel_round_robin;

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       gv;
    } exp_t;

    logic clk;
    logic rstA;
    logic rstB;
    int   checks;
    int   failures;
    exp_t qA[$];
    exp_t qB[$];

    sel_round_robin_if ifA ();
    sel_round_robin_if ifB ();

    sel_round_robin #(.HOLD_MAX(4)) dutA (
        .clk (clk),
        .rst (rstA),
        .bus (ifA)
    );

    sel_round_robin #(.HOLD_MAX(1)) dutB (
        .clk (clk),
        .rst (rstB),
        .bus (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs on the falling edge and records what the outputs must be after the next rising edge.
    task automatic applyStimulus(input int dut, input logic r, input logic [3:0] rq, input logic acc,
                                 input logic [1:0] es, input logic ev, input string nm);
        exp_t e;
        @(negedge clk);
        e.name  = nm;
        e.sel   = es;
        e.gv    = ev;
        e.grant = ev ? (4'b0001 << es) : 4'b0000;
        if (dut == 0) begin
            rstA       = r;
            ifA.req    = rq;
            ifA.accept = acc;
            qA.push_back(e);
        end else begin
            rstB       = r;
            ifB.req    = rq;
            ifB.accept = acc;
            qB.push_back(e);
        end
    endtask

    task automatic checkOutput(input string dutName, input exp_t e, input logic [1:0] s,
                               input logic [3:0] g, input logic v);
        checks++;
        if (s !== e.sel || g !== e.grant || v !== e.gv) begin
            failures++;
            $display("[TB] FAIL %s.%s: got sel=%0d grant=%b gv=%b, want sel=%0d grant=%b gv=%b",
                     dutName, e.name, s, g, v, e.sel, e.grant, e.gv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qA.size() > 0) begin
                e = qA.pop_front();
                checkOutput("A", e, ifA.sel, ifA.grant, ifA.grant_valid);
            end
            if (qB.size() > 0) begin
                e = qB.pop_front();
                checkOutput("B", e, ifB.sel, ifB.grant, ifB.grant_valid);
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rstA       = 1'b1;
        rstB       = 1'b1;
        ifA.req    = 4'b0000;
        ifA.accept = 1'b0;
        ifB.req    = 4'b0000;
        ifB.accept = 1'b0;

        // Reset then first grant goes to source 1 (search starts at 0).
        applyStimulus(0, 1'b1, 4'b1010, 1'b0, 2'd0, 1'b0, "rst0");
        applyStimulus(0, 1'b1, 4'b1010, 1'b0, 2'd0, 1'b0, "rst1");
        applyStimulus(0, 1'b0, 4'b1010, 1'b0, 2'd1, 1'b1, "firstGrant");
        applyStimulus(0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, "dropToIdle");

        // Burst limit and rotation with all requesting.
        applyStimulus(0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, "rst2");
        for (int i = 0; i < 17; i++)
            applyStimulus(0, 1'b0, 4'b1111, 1'b1, 2'((i / 4) % 4), 1'b1, "burstRotate");

        // Withdrawal with another requester waiting, then cnt restart observed via burst length.
        applyStimulus(0, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, "to2");
        applyStimulus(0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, "beat1");
        applyStimulus(0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, "withdraw");
        applyStimulus(0, 1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, "cntRestart0");
        applyStimulus(0, 1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, "cntRestart1");
        applyStimulus(0, 1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, "cntRestart2");
        applyStimulus(0, 1'b0, 4'b0011, 1'b1, 2'd1, 1'b1, "cntRestart3");

        // Withdrawal with nobody else: idle, sel held.
        applyStimulus(0, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, "to2b");
        applyStimulus(0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, "beat1b");
        applyStimulus(0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, "withdrawIdle");

        // Lone requester keeps the grant through self-regrants.
        for (int i = 0; i < 13; i++)
            applyStimulus(0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, "lone");

        // Reset mid-burst abandons the beat count.
        applyStimulus(0, 1'b0, 4'b1000, 1'b0, 2'd3, 1'b1, "to3");
        applyStimulus(0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, "b1");
        applyStimulus(0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, "b2");
        applyStimulus(0, 1'b1, 4'b1000, 1'b1, 2'd0, 1'b0, "rstMid");
        applyStimulus(0, 1'b0, 4'b1000, 1'b0, 2'd3, 1'b1, "regrant3");
        applyStimulus(0, 1'b0, 4'b1001, 1'b1, 2'd3, 1'b1, "afterRst0");
        applyStimulus(0, 1'b0, 4'b1001, 1'b1, 2'd3, 1'b1, "afterRst1");
        applyStimulus(0, 1'b0, 4'b1001, 1'b1, 2'd3, 1'b1, "afterRst2");
        applyStimulus(0, 1'b0, 4'b1001, 1'b1, 2'd0, 1'b1, "afterRst3");
        applyStimulus(0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, "parkA");

        // HOLD_MAX=1: every accept releases, so two requesters alternate.
        applyStimulus(1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, "hm1Rst");
        for (int i = 0; i < 7; i++)
            applyStimulus(1, 1'b0, 4'b0011, 1'b1, 2'(i % 2), 1'b1, "hm1Alt");

        repeat (3) @(negedge clk);
        checks++;
        if (qA.size() != 0 || qB.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got pending A=%0d B=%0d, want 0 and 0", qA.size(), qB.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sel_round_robin.md
# sel_round_robin

Registered round-robin scheduler that drives the 2-bit select of the 4:1 data mux stage downstream. It arbitrates among four request lines, holds a grant for a bounded burst of accepted beats, then rotates fairly. `sel` always carries one of the four valid codes, so the mux is never left with an unhandled select value.

## Interface

**Parameters**
- `HOLD_MAX`, default 4: maximum accepted beats per grant; legal range is 1..16.

**Ports**
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 4: `req[i]` means source i wants the mux.
- `accept`, input, 1: the consumer takes the current mux output this cycle. Ignored unless `grant_valid` is 1.
- `sel`, output, 2: mux select, registered.
- `grant`, output, 4: one-hot copy of `sel`; all zero when idle.
- `grant_valid`, output, 1: a grant is active.

## Operation

- **State machine:** two states, `IDLE` and `GRANT`. Internal registers:
  - `last`, 2 bits: the last source granted.
  - `cnt`: beat counter, `$clog2(HOLD_MAX)` bits, minimum 1 bit.
- **Pick function:** the first index i with `req[i]`=1, searching `last+1`, `last+2`, `last+3`, `last` (mod 4). The current holder is searched last.
- **IDLE:**
  - If `req` is nonzero, go to `GRANT` with `sel`=pick, `grant`=onehot(pick), `grant_valid`=1, `cnt`=0.
  - Otherwise stay in `IDLE`. `sel` holds its value and `grant`=0.
- **GRANT, release conditions:**
  - `accept`=1 and `cnt`=HOLD_MAX-1 (burst complete), or
  - `req[sel]`=0 (source withdrew).
- **GRANT, no release:** if `accept`=1, then `cnt`=`cnt`+1. Otherwise `cnt` holds.
- **GRANT, on release:**
  - `last`=`sel`.
  - If any `req` bit is set, regrant immediately to the pick computed with the updated `last`. `cnt`=0 and there is no idle bubble.
  - Otherwise go to `IDLE` with `grant_valid`=0 and `grant`=0.
- **Simultaneous events:**
  - `accept` together with `req[sel]` dropping counts as one release; the beat is consumed.
  - A source that is alone and finishes its burst is regranted itself on the next cycle.
- **Width rule:** `cnt` never exceeds HOLD_MAX-1. When HOLD_MAX=1, every accept releases the grant.
- **Reset values:** state `IDLE`, `sel`=2'b00, `grant`=4'b0000, `grant_valid`=0, `last`=2'b11, `cnt`=0. With these values the first pick search starts at source 0.

## Timing

- Latency from `req` assertion in `IDLE` to `grant_valid`=1 is 1 cycle.
- Release to the next grant is 0 idle cycles: the new `sel` appears on the edge after the releasing cycle.
- `req[sel]` deasserting drops the grant on the next edge.
- All outputs come from flops. There is no combinational path from any input to any output.
- `rst` asserted mid-burst: on the next edge all outputs take their reset values and the burst is abandoned. `accept` in that cycle is ignored.

## Structure

- **Package `sel_pkg`:**
  - `localparam NUM_SRC = 4`.
  - `typedef logic [1:0] sel_t`.
  - `typedef enum logic {IDLE, GRANT} sched_state_t`.
  - Shared with the mux stage so both use the same `sel_t`.
- **Sub-module `rr_pick`:** purely combinational.
  - Inputs: `req[3:0]`, `last` (`sel_t`).
  - Outputs: `pick` (`sel_t`), `any`.
  - Its `case` covers all four `last` codes and also has a default, so no path leaves `pick` unassigned.
- The top level holds the FSM, `cnt`, `last` and the output flops.

## Test plan

- **Reset and first grant:** `rst`=1 for 2 cycles, then `req`=4'b1010. Expect `sel`=0 / `grant_valid`=0 during reset, then `sel`=1, `grant`=4'b0010, `grant_valid`=1 one cycle after `rst` drops.
- **Burst limit and fair rotation:** `req`=4'b1111, `accept` held at 1, HOLD_MAX=4. Expect `sel` sequence 0,0,0,0,1,1,1,1,2,…,3,0 with no bubble cycles.
- **Withdrawal:** source 2 granted, `req[2]` drops after 1 accepted beat while `req`=4'b0001. Next cycle expect `sel`=0 with `cnt` restarted. If `req`=0 instead, expect `grant_valid`=0 and `sel` held at 2.
- **Lone requester:** `req`=4'b0100 with continuous `accept`. Expect `sel`=2 continuously and `grant_valid` never dropping, through regrants every HOLD_MAX beats.
- **Reset mid-burst:** assert `rst` after 2 beats of a grant to source 3. Expect `sel`=0, `grant`=0, `grant_valid`=0 on the next edge. With `req`=4'b1000 still high, expect a regrant to 3 one cycle after release of `rst`.
- **HOLD_MAX=1:** `req`=4'b0011 with `accept`=1 every cycle. Expect `sel` alternating 0,1,0,1.
